// File: rtl/score_streamer.sv
// Class-score buffer that streams NUM_CLASSES scores in index order with first/last framing.
// Optional build macro SCORE_OFFSET_EN: invert the MSB of fm (two's complement -> offset binary).
module score_streamer #(
  parameter int NUM_CLASSES = 1000,
  parameter int DATA_W      = 16,
  parameter int IDX_W       = 10
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              wr_en,
  input  logic [IDX_W-1:0]  wr_addr,
  input  logic [DATA_W-1:0] wr_data,
  input  logic              start,
  output logic              busy,
  output logic              done,
  output logic              fm_valid,
  input  logic              fm_ready,
  output logic [DATA_W-1:0] fm,
  output logic [IDX_W-1:0]  fm_index,
  output logic              fm_first,
  output logic              fm_last
);

  localparam logic [1:0] S_IDLE   = 2'd0;
  localparam logic [1:0] S_PRIME  = 2'd1;
  localparam logic [1:0] S_STREAM = 2'd2;
  localparam logic [1:0] S_DONE   = 2'd3;

  localparam logic [IDX_W:0] N_EXT = (IDX_W+1)'(NUM_CLASSES);
  localparam logic [IDX_W:0] LAST  = N_EXT - 1'b1;

`ifdef SCORE_OFFSET_EN
  localparam logic [DATA_W-1:0] OUT_MASK = {1'b1, {(DATA_W-1){1'b0}}};
`else
  localparam logic [DATA_W-1:0] OUT_MASK = '0;
`endif

  logic [DATA_W-1:0] mem [NUM_CLASSES];
  logic [1:0]        state;
  logic [IDX_W:0]    rd_next;
  logic [IDX_W-1:0]  rd_addr;
  logic              advance;
  logic              more;
  logic              wr_ok;

  assign rd_addr = rd_next[IDX_W-1:0];
  assign advance = !fm_valid || fm_ready;
  assign more    = rd_next < N_EXT;
  assign wr_ok   = (state == S_IDLE) && wr_en && ({1'b0, wr_addr} < N_EXT);
  assign busy    = (state == S_PRIME) || (state == S_STREAM);
  assign done    = (state == S_DONE);

  always_ff @(posedge clk) begin
    if (wr_ok) mem[wr_addr] <= wr_data;
  end

  // The buffer's read register doubles as the output register, so its
  // enable is the stream advance condition and data holds under backpressure.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state    <= S_IDLE;
      rd_next  <= '0;
      fm_valid <= 1'b0;
      fm       <= '0;
      fm_index <= '0;
      fm_first <= 1'b0;
      fm_last  <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (start) begin
            state   <= S_PRIME;
            rd_next <= '0;
          end
        end
        S_PRIME, S_STREAM: begin
          state <= S_STREAM;
          if (advance) begin
            if (more) begin
              fm       <= mem[rd_addr] ^ OUT_MASK;
              fm_valid <= 1'b1;
              fm_index <= rd_addr;
              fm_first <= (rd_next == '0);
              fm_last  <= (rd_next == LAST);
              rd_next  <= rd_next + 1'b1;
            end else begin
              fm_valid <= 1'b0;
              fm_index <= '0;
              fm_first <= 1'b0;
              fm_last  <= 1'b0;
              state    <= S_DONE;
            end
          end
        end
        S_DONE:  state <= S_IDLE;
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_score_streamer.sv
// Directed bench: 1000-class fill/stream, lockout, mid-frame reset, and a 4-class backpressure/offset instance.
module tb_score_streamer;

`ifdef SCORE_OFFSET_EN
  localparam logic [15:0] MASK = 16'h8000;
`else
  localparam logic [15:0] MASK = 16'h0000;
`endif

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic        b_wr_en, b_start, b_busy, b_done, b_fm_valid, b_fm_ready, b_fm_first, b_fm_last;
  logic [9:0]  b_wr_addr, b_fm_index;
  logic [15:0] b_wr_data, b_fm;

  logic        s_wr_en, s_start, s_busy, s_done, s_fm_valid, s_fm_ready, s_fm_first, s_fm_last;
  logic [1:0]  s_wr_addr, s_fm_index;
  logic [15:0] s_wr_data, s_fm;

  int n_assert = 0;
  int n_fail   = 0;

  score_streamer #(.NUM_CLASSES(1000), .DATA_W(16), .IDX_W(10)) u_big (
    .clk(clk), .rst(rst), .wr_en(b_wr_en), .wr_addr(b_wr_addr), .wr_data(b_wr_data),
    .start(b_start), .busy(b_busy), .done(b_done), .fm_valid(b_fm_valid), .fm_ready(b_fm_ready),
    .fm(b_fm), .fm_index(b_fm_index), .fm_first(b_fm_first), .fm_last(b_fm_last)
  );

  score_streamer #(.NUM_CLASSES(4), .DATA_W(16), .IDX_W(2)) u_small (
    .clk(clk), .rst(rst), .wr_en(s_wr_en), .wr_addr(s_wr_addr), .wr_data(s_wr_data),
    .start(s_start), .busy(s_busy), .done(s_done), .fm_valid(s_fm_valid), .fm_ready(s_fm_ready),
    .fm(s_fm), .fm_index(s_fm_index), .fm_first(s_fm_first), .fm_last(s_fm_last)
  );

  function automatic logic [31:0] pk(input logic busy, input logic valid, input logic first,
                                     input logic last, input logic done, input logic [9:0] idx,
                                     input logic [15:0] data);
    return {1'b0, busy, valid, first, last, done, idx, data};
  endfunction

  function automatic logic [31:0] big_obs();
    return pk(b_busy, b_fm_valid, b_fm_first, b_fm_last, b_done, b_fm_index, b_fm);
  endfunction

  function automatic logic [31:0] small_obs();
    return pk(s_busy, s_fm_valid, s_fm_first, s_fm_last, s_done, {8'd0, s_fm_index}, s_fm);
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Streams the 1000-entry buffer with fm_ready high; v2 is the expected score at index 2.
  task automatic stream_big(input int abort_at, input int inject_at, input logic [15:0] v2);
    logic [15:0] ev;
    @(negedge clk);
    b_start = 1'b1;
    @(negedge clk);
    b_start = 1'b0;
    chk("big_prime", {29'd0, b_busy, b_fm_valid, b_done}, 32'b100);
    for (int k = 0; k < 1000; k++) begin
      @(negedge clk);
      b_start = 1'b0;
      b_wr_en = 1'b0;
      ev = (k == 2) ? v2 : 16'(k * 3);
      chk($sformatf("big_k%0d", k), big_obs(),
          pk(1'b1, 1'b1, k == 0, k == 999, 1'b0, 10'(k), ev ^ MASK));
      if (k == inject_at) begin
        b_start   = 1'b1;
        b_wr_en   = 1'b1;
        b_wr_addr = 10'd2;
        b_wr_data = 16'h7FFF;
      end
      if (k == abort_at) begin
        rst = 1'b0;
        #1;
        chk("big_async_reset", big_obs(), 32'd0);
        chk("small_async_reset", small_obs(), 32'd0);
        @(negedge clk);
        rst = 1'b1;
        return;
      end
    end
    @(negedge clk);
    chk("big_done", big_obs(), pk(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 10'd0, 16'd0) | 32'(b_fm));
    @(negedge clk);
    chk("big_done_clear", {28'd0, b_busy, b_fm_valid, b_done, 1'b0}, 32'd0);
  endtask

  logic        rdy_tab [7];
  logic [15:0] sev [4];
  int          exp_k;
  int          hs;

  initial begin
    rst = 1'b1;
    b_wr_en = 1'b0; b_wr_addr = '0; b_wr_data = '0; b_start = 1'b0; b_fm_ready = 1'b0;
    s_wr_en = 1'b0; s_wr_addr = '0; s_wr_data = '0; s_start = 1'b0; s_fm_ready = 1'b0;
    #2 rst = 1'b0;
    @(negedge clk);
    chk("big_reset", big_obs(), 32'd0);
    chk("small_reset", small_obs(), 32'd0);
    rst = 1'b1;

    for (int i = 0; i < 1000; i++) begin
      @(negedge clk);
      b_wr_en   = 1'b1;
      b_wr_addr = 10'(i);
      b_wr_data = 16'(i * 3);
      s_wr_en   = (i < 4);
      s_wr_addr = 2'(i);
      s_wr_data = 16'((i + 1) * 10);
    end
    @(negedge clk);
    s_wr_en   = 1'b0;
    b_wr_addr = 10'd1000;
    b_wr_data = 16'hDEAD;
    @(negedge clk);
    b_wr_en = 1'b0;
    chk("idle_after_fill", {30'd0, b_busy, b_fm_valid}, 32'd0);

    b_fm_ready = 1'b1;
    stream_big(-1, 500, 16'd6);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("start_ignored_idle", {29'd0, b_busy, b_fm_valid, b_done}, 32'd0);
    end
    stream_big(-1, -1, 16'd6);
    stream_big(500, -1, 16'd6);
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk("no_done_after_reset", {29'd0, b_busy, b_fm_valid, b_done}, 32'd0);
    end
    stream_big(-1, -1, 16'd6);

    rdy_tab = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1};
    exp_k = 0;
    hs    = 0;
    @(negedge clk);
    s_start    = 1'b1;
    s_fm_ready = 1'b1;
    @(negedge clk);
    s_start = 1'b0;
    chk("small_prime", {29'd0, s_busy, s_fm_valid, s_done}, 32'b100);
    for (int i = 0; i < 7; i++) begin
      @(negedge clk);
      s_fm_ready = rdy_tab[i];
      chk($sformatf("bp_cyc%0d", i), small_obs(),
          pk(1'b1, 1'b1, exp_k == 0, exp_k == 3, 1'b0, 10'(exp_k), 16'((exp_k + 1) * 10) ^ MASK));
      if (s_fm_valid && s_fm_ready) begin
        exp_k++;
        hs++;
      end
    end
    @(negedge clk);
    chk("bp_done", {29'd0, s_busy, s_fm_valid, s_done}, 32'b001);
    chk("bp_handshakes", 32'(hs), 32'd4);

    sev = '{16'hFFFF, 16'h0001, 16'd30, 16'd40};
    @(negedge clk);
    s_wr_en = 1'b1; s_wr_addr = 2'd1; s_wr_data = 16'h0001;
    @(negedge clk);
    s_wr_addr = 2'd0; s_wr_data = 16'hFFFF; s_start = 1'b1;
    @(negedge clk);
    s_wr_en = 1'b0; s_start = 1'b0;
    chk("ofs_prime", {29'd0, s_busy, s_fm_valid, s_done}, 32'b100);
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      chk($sformatf("ofs_k%0d", k), small_obs(),
          pk(1'b1, 1'b1, k == 0, k == 3, 1'b0, 10'(k), sev[k] ^ MASK));
    end
    @(negedge clk);
    chk("ofs_done", {29'd0, s_busy, s_fm_valid, s_done}, 32'b001);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
